// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: issues word reads for PC requests, holds returned
// instructions in an in-order {pc, inst} FIFO and drops in-flight reads on a jump.
module ifetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RST_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        jump_en_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] disc_cnt;
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] dat_wr;
  logic [AW-1:0] dat_rd;
  logic [31:0]   tag_mem  [DEPTH];
  logic [31:0]   dat_pc   [DEPTH];
  logic [31:0]   dat_inst [DEPTH];

  logic [SW-1:0] occupancy;
  logic          credit;
  logic          accept;
  logic          resp_keep;
  logic          resp_drop;
  logic          pop;

  // Stale responses still owe a slot, so they count against credit too.
  assign occupancy  = SW'(out_cnt) + SW'(buf_cnt) + SW'(disc_cnt);
  assign credit     = occupancy < SW'(DEPTH);
  assign mem_req_o  = pc_valid_i & credit & ~jump_en_i;
  assign pc_ready_o = mem_req_o & mem_gnt_i;
  assign mem_addr_o = {pc_i[31:2], 2'b00};
  assign accept     = pc_ready_o;
  assign resp_keep  = mem_rvalid_i & (disc_cnt == '0);
  assign resp_drop  = mem_rvalid_i & (disc_cnt != '0);

  assign inst_valid_o = buf_cnt != '0;
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = dat_inst[dat_rd];
  assign inst_pc_o    = dat_pc[dat_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      buf_cnt  <= '0;
      disc_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      dat_wr   <= '0;
      dat_rd   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem[AW'(i)]  <= '0;
        dat_pc[AW'(i)]   <= '0;
        dat_inst[AW'(i)] <= RST_INST;
      end
    end else if (jump_en_i) begin
      // Everything granted so far becomes stale; a response landing now is one of them.
      tag_wr   <= '0;
      tag_rd   <= '0;
      dat_wr   <= '0;
      dat_rd   <= '0;
      buf_cnt  <= '0;
      out_cnt  <= '0;
      disc_cnt <= disc_cnt + out_cnt - CW'(mem_rvalid_i);
    end else begin
      if (accept) begin
        tag_mem[tag_wr] <= pc_i;
        tag_wr          <= tag_wr + AW'(1);
      end
      if (resp_keep) begin
        dat_pc[dat_wr]   <= tag_mem[tag_rd];
        dat_inst[dat_wr] <= mem_rdata_i;
        dat_wr           <= dat_wr + AW'(1);
        tag_rd           <= tag_rd + AW'(1);
      end
      if (pop) begin
        dat_rd <= dat_rd + AW'(1);
      end
      out_cnt  <= out_cnt + CW'(accept) - CW'(resp_keep);
      buf_cnt  <= buf_cnt + CW'(resp_keep) - CW'(pop);
      disc_cnt <= disc_cnt - CW'(resp_drop);
    end
  end

endmodule
